gate_not_checker: RTL and testbench
===================================

Name: gate_not_checker

Overview:
- Synthesizable response checker for the gate_not block under test: the receiving end of the NOT-gate stimulus stream.
- Samples the applied stimulus and both DUT outputs (operator form and primitive-instance form) every clock. It delays the stimulus by the DUT latency, compares each output against the inverted expected value, counts tests and errors, and reports a pass/fail verdict.
- Sits beside the DUT in self-checking benches and in FPGA smoke tests where no simulator $monitor is available.

Parameters:
- TEST_NUMBER, 5, number of samples checked per run; legal range 1..2^CNT_W-1.
- LATENCY, 0, clock cycles between a stimulus change and the valid DUT response; legal range 0..3.
- CNT_W, 8, width of test and error counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  rising-edge request to begin a run; level-sampled, acted on only in IDLE or DONE.
- signal  in  1  stimulus currently driven into the DUT.
- not_logic  in  1  DUT output, operator implementation.
- not_instance  in  1  DUT output, primitive-instance implementation.
- busy  out  1  high in FILL and CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1; 1 when error_count==0.
- mismatch  out  1  one-cycle pulse on the cycle after a failing compare.
- test_count  out  CNT_W  samples checked in the current run.
- error_count  out  CNT_W  failing samples in the current run, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, pass, mismatch = 0; both counters = 0; delay line = 0.
- Delay line: LATENCY-deep shift register of signal. expected = ~delayed_signal. When LATENCY=0, expected = ~signal sampled in the same cycle.
- FSM states: IDLE, FILL, CHECK, DONE.
- IDLE: on start=1, clear both counters. Go to FILL if LATENCY>0, otherwise go to CHECK.
- FILL: shift the delay line for exactly LATENCY cycles with no compares, then go to CHECK.
- CHECK, per cycle:
  - fail = (not_logic != expected) | (not_instance != expected).
  - test_count increments by 1.
  - On fail, error_count increments, saturating at 2^CNT_W-1; mismatch pulses 1 in the following cycle.
  - When test_count reaches TEST_NUMBER (the compare on that cycle is included), go to DONE.
- DONE: done=1, pass=(error_count==0). Outputs and counters hold. start=1 clears counters, drops done, and restarts exactly as from IDLE.
- start while busy is ignored; a run cannot be aborted except by reset.
- Reset mid-run returns to IDLE immediately. No partial verdict is retained.
- The delay line shifts every cycle in all states, so expected is correct on the first CHECK cycle.
- Simulation only: X or Z on either DUT output counts as a fail, using case-inequality semantics.

Optional Feature:
- Macro: GATE_NOT_CHECKER_TRACE_EN.
- With the macro: each CHECK cycle issues one $display line of the form "<test_count> - Time = <t> | signal = <b> -> expected = <b>, ~ = <b>, not = <b> [FAIL]". A summary "PASS"/"FAIL n/N" line is printed on entry to DONE.
- Without the macro: no system tasks are compiled; the RTL is fully synthesizable. Port behaviour is identical in both cases.

Test Plan:
- Reset check: assert rst_n=0 mid-CHECK -> all outputs 0 within the same cycle, state IDLE; release, then start -> a clean run of 5 tests.
- Correct DUT, LATENCY=0, TEST_NUMBER=5: signal toggles each cycle, outputs = ~signal -> done=1 after 5 CHECK cycles, test_count=5, error_count=0, pass=1, mismatch never pulses.
- not_instance stuck at 0 on the third sample only -> error_count=1, exactly one mismatch pulse one cycle after that sample, pass=0.
- LATENCY=2, DUT modelled with a 2-cycle pipeline -> FILL lasts 2 cycles, pass=1. Same stimulus with LATENCY=0 -> error_count equals the number of toggled samples.
- CNT_W=2, TEST_NUMBER=3, all samples failing -> error_count=3 saturated, pass=0. start pulse in DONE -> counters clear to 0 and busy rises next cycle.
- start held high during CHECK -> no restart; counts continue uninterrupted to TEST_NUMBER.

Source files
------------

// File: rtl/gate_not_checker.sv
// Response checker for the gate_not block: compares both NOT outputs against the delayed, inverted stimulus.
// Define GATE_NOT_CHECKER_TRACE_EN to print a per-sample trace and a final verdict in simulation.
module gate_not_checker #(
    parameter int TEST_NUMBER = 5,
    parameter int LATENCY     = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signal,
    input  logic             not_logic,
    input  logic             not_instance,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] test_count,
    output logic [CNT_W-1:0] error_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TEST_NUMBER);
    localparam logic [1:0]       FILL_LAST = 2'(LATENCY - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_test_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [1:0]       r_fill_cnt;
    logic             r_mismatch;

    logic             w_expected;
    logic             w_fail;
    logic             w_start_run;
    logic             w_last;
    logic [CNT_W-1:0] w_test_inc;
    logic [CNT_W-1:0] w_err_inc;

    // The delay line runs in every state so it is already primed when CHECK begins.
    generate
        if (LATENCY == 0) begin : g_no_dly
            assign w_expected = ~signal;
        end else begin : g_dly
            logic [LATENCY-1:0] r_dly;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dly <= '0;
                end else begin
                    r_dly[0] <= signal;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign w_expected = ~r_dly[LATENCY-1];
        end
    endgenerate

    // Case inequality makes X/Z on a DUT output a failure in simulation; synthesis sees plain !=.
    assign w_fail      = (not_logic !== w_expected) || (not_instance !== w_expected);
    assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_test_inc  = r_test_cnt + CNT_ONE;
    assign w_last      = (w_test_inc == CNT_LAST);
    assign w_err_inc   = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + CNT_ONE;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = (LATENCY > 0) ? S_FILL : S_CHECK;
            S_FILL:         if (r_fill_cnt == FILL_LAST) w_next = S_CHECK;
            S_CHECK:        if (w_last) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_test_cnt <= '0;
            r_err_cnt  <= '0;
            r_fill_cnt <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_mismatch <= (r_state == S_CHECK) && w_fail;
            if (w_start_run) begin
                r_test_cnt <= '0;
                r_err_cnt  <= '0;
                r_fill_cnt <= '0;
            end else if (r_state == S_CHECK) begin
                r_test_cnt <= w_test_inc;
                if (w_fail) r_err_cnt <= w_err_inc;
            end else if (r_state == S_FILL) begin
                r_fill_cnt <= r_fill_cnt + 2'd1;
            end
        end
    end

    assign busy        = (r_state == S_FILL) || (r_state == S_CHECK);
    assign done        = (r_state == S_DONE);
    assign pass        = done && (r_err_cnt == '0);
    assign mismatch    = r_mismatch;
    assign test_count  = r_test_cnt;
    assign error_count = r_err_cnt;

`ifdef GATE_NOT_CHECKER_TRACE_EN
    logic [CNT_W-1:0] w_err_final;
    assign w_err_final = w_fail ? w_err_inc : r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst_n && (r_state == S_CHECK)) begin
            $display("%0d - Time = %0t | signal = %b -> expected = %b, ~ = %b, not = %b%s",
                     w_test_inc, $time, signal, w_expected, not_logic, not_instance,
                     w_fail ? " FAIL" : "");
            if (w_last) begin
                if (w_err_final == '0) $display("PASS");
                else                   $display("FAIL %0d/%0d", w_err_final, w_test_inc);
            end
        end
    end
`endif

endmodule

// File: tb/tb_gate_not_checker.sv
// Self-checking bench for gate_not_checker: table vectors, hand sequences and randomized runs
// against a history-based reference model, over three parameterisations.
module tb_gate_not_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, sig, start0, start2, start3, nl0, ni0, use_pipe0;
    logic pipe1 = 1'b0;
    logic pipe2 = 1'b0;
    logic w_nl0, w_ni0;

    // Model of a two-cycle pipelined NOT gate.
    always @(posedge clk) begin
        pipe1 <= ~sig;
        pipe2 <= pipe1;
    end

    assign w_nl0 = use_pipe0 ? pipe2 : nl0;
    assign w_ni0 = use_pipe0 ? pipe2 : ni0;

    logic       busy0, done0, pass0, mm0;
    logic [7:0] tc0, ec0;
    logic       busy2, done2, pass2, mm2;
    logic [7:0] tc2, ec2;
    logic       busy3, done3, pass3, mm3;
    logic [1:0] tc3, ec3;

    gate_not_checker #(.TEST_NUMBER(5), .LATENCY(0), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .signal(sig),
        .not_logic(w_nl0), .not_instance(w_ni0),
        .busy(busy0), .done(done0), .pass(pass0), .mismatch(mm0),
        .test_count(tc0), .error_count(ec0)
    );

    gate_not_checker #(.TEST_NUMBER(5), .LATENCY(2), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .signal(sig),
        .not_logic(pipe2), .not_instance(pipe2),
        .busy(busy2), .done(done2), .pass(pass2), .mismatch(mm2),
        .test_count(tc2), .error_count(ec2)
    );

    // Outputs tied to the stimulus itself: every sample fails.
    gate_not_checker #(.TEST_NUMBER(3), .LATENCY(0), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .signal(sig),
        .not_logic(sig), .not_instance(sig),
        .busy(busy3), .done(done3), .pass(pass3), .mismatch(mm3),
        .test_count(tc3), .error_count(ec3)
    );

    typedef struct {
        logic sig;
        logic nl;
        logic ni;
        logic exp_fail;
    } vec_t;

    vec_t vecs[10];
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;
    logic sig_hist[4096];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock: record the stimulus seen at the rising edge, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (edge_n < 4096) sig_hist[edge_n] = sig;
        @(negedge clk);
    endtask

    // Errors a checker of latency lat_chk sees from an ideal NOT gate of latency lat_dut.
    function automatic int model_errors(int first, int n, int lat_dut, int lat_chk, int w);
        int e = 0;
        for (int k = first; k < first + n; k++) begin
            if (sig_hist[k - lat_dut] != sig_hist[k - lat_chk]) e++;
        end
        if (e > (1 << w) - 1) e = (1 << w) - 1;
        return e;
    endfunction

    task automatic run_table(input int base);
        vec_t v;
        int   errs = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("tbl_busy_start", 32'(busy0), 1);
        check("tbl_tc_start", 32'(tc0), 0);
        for (int i = 0; i < 5; i++) begin
            v   = vecs[base + i];
            sig = v.sig;
            nl0 = v.nl;
            ni0 = v.ni;
            tick();
            if (v.exp_fail) errs++;
            check("tbl_tc", 32'(tc0), 32'(i + 1));
            check("tbl_mismatch", 32'(mm0), 32'(v.exp_fail));
            check("tbl_ec", 32'(ec0), 32'(errs));
            check("tbl_busy", 32'(busy0), 32'(i < 4));
            check("tbl_done", 32'(done0), 32'(i == 4));
        end
        check("tbl_pass", 32'(pass0), 32'(errs == 0));
        tick();
        check("tbl_hold_done", 32'(done0), 1);
        check("tbl_hold_tc", 32'(tc0), 5);
        check("tbl_hold_ec", 32'(ec0), 32'(errs));
        check("tbl_hold_mm", 32'(mm0), 0);
    endtask

    task automatic rand_run();
        int e0, k, exp0, exp2;
        use_pipe0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sig = 1'($urandom);
            tick();
        end
        start0 = 1'b1;
        start2 = 1'b1;
        sig    = 1'($urandom);
        tick();
        e0     = edge_n;
        start0 = 1'b0;
        start2 = 1'b0;
        check("rnd_busy2_start", 32'(busy2), 1);
        for (int c = 1; c <= 7; c++) begin
            sig = 1'($urandom);
            tick();
            k = e0 + c;
            if (c <= 5) check("rnd_mm0", 32'(mm0), 32'(sig_hist[k] != sig_hist[k - 2]));
            if (c <= 2) check("rnd_fill_tc2", 32'(tc2), 0);
            if (c == 2) check("rnd_fill_busy2", 32'(busy2), 1);
            if (c == 3) check("rnd_first_check_tc2", 32'(tc2), 1);
        end
        exp0 = model_errors(e0 + 1, 5, 2, 0, 8);
        exp2 = model_errors(e0 + 3, 5, 2, 2, 8);
        check("rnd_ec0", 32'(ec0), 32'(exp0));
        check("rnd_tc0", 32'(tc0), 5);
        check("rnd_done0", 32'(done0), 1);
        check("rnd_pass0", 32'(pass0), 32'(exp0 == 0));
        check("rnd_ec2", 32'(ec2), 32'(exp2));
        check("rnd_tc2", 32'(tc2), 5);
        check("rnd_done2", 32'(done2), 1);
        check("rnd_pass2", 32'(pass2), 1);
        use_pipe0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:4] s_ok;
        logic [0:4] s_bad;
        s_ok  = 5'b01010;
        s_bad = 5'b10010;
        for (int i = 0; i < 5; i++) begin
            vecs[i]     = '{sig: s_ok[i], nl: ~s_ok[i], ni: ~s_ok[i], exp_fail: 1'b0};
            vecs[5 + i] = '{sig: s_bad[i], nl: ~s_bad[i], ni: (i == 2) ? 1'b0 : ~s_bad[i],
                            exp_fail: (i == 2)};
        end

        rst_n = 1'b0; sig = 1'b0; start0 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        nl0 = 1'b1; ni0 = 1'b1; use_pipe0 = 1'b0;
        tick();
        tick();
        check("rst_busy0", 32'(busy0), 0);
        check("rst_done0", 32'(done0), 0);
        check("rst_pass0", 32'(pass0), 0);
        check("rst_mm0", 32'(mm0), 0);
        check("rst_tc0", 32'(tc0), 0);
        check("rst_ec0", 32'(ec0), 0);
        check("rst_busy2", 32'(busy2), 0);
        check("rst_done3", 32'(done3), 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy0", 32'(busy0), 0);

        run_table(0);
        run_table(5);

        // start held high through CHECK must not restart the run.
        start0 = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            sig = 1'($urandom);
            nl0 = ~sig;
            ni0 = ~sig;
            tick();
            check("held_tc", 32'(tc0), 32'(c));
            check("held_busy", 32'(busy0), 32'(c < 5));
        end
        start0 = 1'b0;
        check("held_done", 32'(done0), 1);
        check("held_pass", 32'(pass0), 1);
        tick();
        check("held_done_hold", 32'(done0), 1);
        check("held_tc_hold", 32'(tc0), 5);

        // Reset in the middle of CHECK, with a mismatch pulse outstanding.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        sig = 1'b0; nl0 = 1'b1; ni0 = 1'b1;
        tick();
        sig = 1'b1; nl0 = 1'b1; ni0 = 1'b0;
        tick();
        check("mid_tc", 32'(tc0), 2);
        check("mid_ec", 32'(ec0), 1);
        check("mid_mm", 32'(mm0), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy0), 0);
        check("mid_rst_done", 32'(done0), 0);
        check("mid_rst_pass", 32'(pass0), 0);
        check("mid_rst_mm", 32'(mm0), 0);
        check("mid_rst_tc", 32'(tc0), 0);
        check("mid_rst_ec", 32'(ec0), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(busy0), 0);
        run_table(0);

        for (int r = 0; r < 4; r++) rand_run();

        // All-failing run on the narrow-counter instance, then restart from DONE.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("sat_busy", 32'(busy3), 1);
        for (int c = 1; c <= 3; c++) begin
            sig = 1'($urandom);
            tick();
            check("sat_tc", 32'(tc3), 32'(c));
            check("sat_ec", 32'(ec3), 32'(c));
            check("sat_mm", 32'(mm3), 1);
        end
        check("sat_done", 32'(done3), 1);
        check("sat_pass", 32'(pass3), 0);
        tick();
        check("sat_hold_ec", 32'(ec3), 3);
        check("sat_hold_mm", 32'(mm3), 0);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("restart_tc", 32'(tc3), 0);
        check("restart_ec", 32'(ec3), 0);
        check("restart_done", 32'(done3), 0);
        check("restart_busy", 32'(busy3), 1);
        for (int c = 0; c < 4; c++) tick();
        check("restart_final_done", 32'(done3), 1);
        check("restart_final_ec", 32'(ec3), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
